// File: rtl/switch_io_port_if.sv
// Switch/display signal bundle between the CPU side (master) and switch_io_port (slave).
// The sw_irq signal exists only when IO_PORT_IRQ_EN is defined.
interface switch_io_port_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] switches;
  logic              rd_sw;
  logic              wr_disp;
  logic [WORD_W-1:0] display;
  logic              sw_ready;
`ifdef IO_PORT_IRQ_EN
  logic              sw_irq;

  modport master (
    output switches, rd_sw, wr_disp,
    input  display, sw_ready, sw_irq
  );
  modport slave (
    input  switches, rd_sw, wr_disp,
    output display, sw_ready, sw_irq
  );
`else
  modport master (
    output switches, rd_sw, wr_disp,
    input  display, sw_ready
  );
  modport slave (
    input  switches, rd_sw, wr_disp,
    output display, sw_ready
  );
`endif
endinterface

// File: rtl/switch_io_port.sv
// switch_io_port: synchronises and debounces switches, serves CPU reads on sysbus, holds the display register.
// Optional IO_PORT_IRQ_EN adds a registered one-cycle sw_irq pulse whenever sw_ready rises.
module switch_io_port #(
  parameter int WORD_W          = 8,
  parameter int DEBOUNCE_W      = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic              clock,
  input  logic              reset,
  inout  wire  [WORD_W-1:0] sysbus,
  switch_io_port_if.slave   io
);

  localparam logic [DEBOUNCE_W-1:0] CNT_MAX = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  logic [WORD_W-1:0]     sync1;
  logic [WORD_W-1:0]     sync2;
  logic [WORD_W-1:0]     cand;
  logic [DEBOUNCE_W-1:0] cnt;
  logic [WORD_W-1:0]     sw_reg;
  logic [WORD_W-1:0]     display_q;
  logic                  sw_ready_q;
  logic                  commit;
  logic                  disp_load;

  // A value commits only once it has been stable for the full count and differs from what is held.
  assign commit    = (sync2 == cand) && (cnt == CNT_MAX) && (cand != sw_reg);
  assign disp_load = io.wr_disp && !io.rd_sw;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      cand       <= '0;
      cnt        <= '0;
      sw_reg     <= '0;
      display_q  <= '0;
      sw_ready_q <= 1'b0;
    end else begin
      sync1 <= io.switches;
      sync2 <= sync1;

      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + DEBOUNCE_W'(1);
      end

      // A commit on the same edge as a read keeps the new value flagged.
      if (commit) begin
        sw_reg     <= cand;
        sw_ready_q <= 1'b1;
      end else if (io.rd_sw) begin
        sw_ready_q <= 1'b0;
      end

      if (disp_load) begin
        display_q <= sysbus;
      end
    end
  end

  assign sysbus      = io.rd_sw ? sw_reg : 'z;
  assign io.display  = display_q;
  assign io.sw_ready = sw_ready_q;

`ifdef IO_PORT_IRQ_EN
  logic sw_irq_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_irq_q <= 1'b0;
    end else begin
      sw_irq_q <= commit && !sw_ready_q;
    end
  end

  assign io.sw_irq = sw_irq_q;
`endif

endmodule

// File: tb/tb_switch_io_port.sv
// Bench for switch_io_port with DEBOUNCE_CYCLES=8: table-driven clean changes plus hand-written
// sequences for reset, bounce, display writes, read/commit collision and reset mid-debounce.
module tb_switch_io_port;

  logic       clock;
  logic       reset;
  wire  [7:0] sysbus;
  logic [7:0] tb_bus;
  logic       tb_bus_en;

  switch_io_port_if #(.WORD_W(8)) io ();

  switch_io_port #(
    .WORD_W         (8),
    .DEBOUNCE_W     (16),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sysbus(sysbus),
    .io    (io.slave)
  );

  assign sysbus = tb_bus_en ? tb_bus : 'z;

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int ntests = 0;
  int nfail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_sw;

  typedef struct {
    logic [7:0] sw;
    logic       commit;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bench drives the complement of the held value; any DUT drive would corrupt it.
  task automatic probe_idle(input string name);
    tb_bus    = ~model_sw;
    tb_bus_en = 1'b1;
    #1;
    check8(name, sysbus, ~model_sw);
    tb_bus_en = 1'b0;
  endtask

  task automatic do_read(input string name, input logic exp_ready_after);
    logic [7:0] e;
    io.rd_sw = 1'b1;
    #1;
    if (exp_q.size() == 0) begin
      ntests++;
      nfail++;
      $display("FAIL %s_bus: read with empty scoreboard, got %h", name, sysbus);
    end else begin
      e = exp_q.pop_front();
      check8({name, "_bus"}, sysbus, e);
    end
    tick();
    io.rd_sw = 1'b0;
    check1({name, "_ready_after"}, io.sw_ready, exp_ready_after);
    probe_idle({name, "_idle"});
  endtask

  task automatic write_disp(input logic [7:0] v);
    tb_bus     = v;
    tb_bus_en  = 1'b1;
    io.wr_disp = 1'b1;
    tick();
    io.wr_disp = 1'b0;
    tb_bus_en  = 1'b0;
  endtask

`ifdef IO_PORT_IRQ_EN
  logic prev_ready = 1'b0;
  always @(negedge clock) begin
    check1("irq_pulse", io.sw_irq, io.sw_ready & ~prev_ready);
    prev_ready = io.sw_ready;
  end
`endif

  initial begin
    int ready_hits;

    vecs[0] = '{8'h00, 1'b1};
    vecs[1] = '{8'h01, 1'b1};
    vecs[2] = '{8'h01, 1'b0};
    vecs[3] = '{8'hA5, 1'b1};
    vecs[4] = '{8'hFF, 1'b1};
    vecs[5] = '{8'h5A, 1'b1};

    reset       = 1'b1;
    io.switches = 8'h3C;
    io.rd_sw    = 1'b0;
    io.wr_disp  = 1'b0;
    tb_bus      = 8'h00;
    tb_bus_en   = 1'b0;
    model_sw    = 8'h00;

    // Reset with switches already at 3C.
    repeat (2) tick();
    check8("rst_display", io.display, 8'h00);
    check1("rst_ready", io.sw_ready, 1'b0);
    probe_idle("rst_idle");
    reset = 1'b0;
    exp_q.push_back(8'h3C);
    model_sw = 8'h3C;
    repeat (10) tick();
    check1("rst_ready_e10", io.sw_ready, 1'b0);
    tick();
    check1("rst_ready_e11", io.sw_ready, 1'b1);
    do_read("rst_read", 1'b0);

    // Clean changes.
    for (int i = 0; i < 6; i++) begin
      io.switches = vecs[i].sw;
      if (vecs[i].commit) begin
        exp_q.push_back(vecs[i].sw);
        model_sw = vecs[i].sw;
      end
      repeat (10) tick();
      check1($sformatf("vec%0d_ready_e10", i), io.sw_ready, 1'b0);
      tick();
      check1($sformatf("vec%0d_ready_e11", i), io.sw_ready, vecs[i].commit);
      if (vecs[i].commit) do_read($sformatf("vec%0d_read", i), 1'b0);
      else probe_idle($sformatf("vec%0d_idle", i));
    end

    // Bounce between 05 and 06, settling on 06.
    ready_hits = 0;
    for (int i = 0; i < 10; i++) begin
      io.switches = (i % 2 == 0) ? 8'h05 : 8'h06;
      if (i == 9) begin
        exp_q.push_back(8'h06);
        model_sw = 8'h06;
      end
      repeat (3) begin
        tick();
        if (io.sw_ready) ready_hits++;
      end
    end
    repeat (7) begin
      tick();
      if (io.sw_ready) ready_hits++;
    end
    check8("bounce_no_early_commit", 8'(ready_hits), 8'd0);
    tick();
    check1("bounce_ready", io.sw_ready, 1'b1);
    do_read("bounce_read", 1'b0);

    // Glitch away and back to the committed value.
    io.switches = 8'h07;
    repeat (3) tick();
    io.switches = 8'h06;
    ready_hits = 0;
    repeat (15) begin
      tick();
      if (io.sw_ready) ready_hits++;
    end
    check8("return_no_ready", 8'(ready_hits), 8'd0);

    // Display writes, then an illegal simultaneous read and write.
    write_disp(8'hC3);
    check8("disp_c3", io.display, 8'hC3);
    write_disp(8'hA5);
    check8("disp_a5", io.display, 8'hA5);
    io.wr_disp = 1'b1;
    exp_q.push_back(model_sw);
    do_read("illegal_rw", 1'b0);
    io.wr_disp = 1'b0;
    check8("illegal_disp_hold", io.display, 8'hA5);

    // Read on the commit edge of 07.
    io.switches = 8'h07;
    exp_q.push_back(8'h06);
    repeat (10) tick();
    check1("collide_ready_e10", io.sw_ready, 1'b0);
    do_read("collide", 1'b1);
    model_sw = 8'h07;
    exp_q.push_back(8'h07);
    do_read("collide_after", 1'b0);

    // Reset five edges into qualifying 10.
    io.switches = 8'h10;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check1("midrst_ready", io.sw_ready, 1'b0);
    check8("midrst_display", io.display, 8'h00);
    exp_q.push_back(8'h10);
    model_sw = 8'h10;
    repeat (10) tick();
    check1("midrst_ready_e10", io.sw_ready, 1'b0);
    tick();
    check1("midrst_ready_e11", io.sw_ready, 1'b1);
    do_read("midrst_read", 1'b0);

    check8("scoreboard_empty", 8'(exp_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
